// File: rtl/instr_decode_stage.sv
// RV32I decode stage: combinational decode feeding a registered output stage
// backed by a one-entry skid buffer so in_ready never depends on out_ready.
module instr_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic        src_a_sel,
    output logic [1:0]  src_b_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal,
    output logic [31:0] out_pc
);

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        src_a_sel;
        logic [1:0]  src_b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
        logic [31:0] pc;
    } dec_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Shared funct3 -> ALU op mapping for OP and OP-IMM; alt selects sra over srl.
    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_op = 4'b0010;
            3'b001:  f3_op = 4'b0101;
            3'b010:  f3_op = 4'b1000;
            3'b011:  f3_op = 4'b1001;
            3'b100:  f3_op = 4'b1100;
            3'b101:  f3_op = alt ? 4'b0111 : 4'b0110;
            3'b110:  f3_op = 4'b1011;
            default: f3_op = 4'b1010;
        endcase
    endfunction

    dec_t dec;

    always_comb begin
        dec           = '0;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];
        dec.pc        = in_pc;
        case (opcode)
            7'b0110111: begin dec.src_b_sel = 2'b01; dec.imm = imm_u; dec.rd_we = 1'b1; end
            7'b0010111: begin
                dec.alu_op = 4'b0010; dec.src_a_sel = 1'b1; dec.src_b_sel = 2'b01;
                dec.imm = imm_u; dec.rd_we = 1'b1;
            end
            7'b1101111: begin dec.alu_op = 4'b0001; dec.src_b_sel = 2'b10; dec.imm = imm_j; dec.rd_we = 1'b1; end
            7'b1100111: begin
                dec.alu_op = 4'b0100; dec.src_b_sel = 2'b01; dec.imm = imm_i; dec.rd_we = 1'b1;
                dec.illegal = (funct3 != 3'b000);
            end
            7'b1100011: begin
                dec.alu_op = 4'b0011; dec.imm = imm_b;
                dec.illegal = (funct3[2:1] == 2'b01);
            end
            7'b0000011: begin
                dec.alu_op = 4'b0010; dec.src_b_sel = 2'b01; dec.imm = imm_i; dec.rd_we = 1'b1;
                dec.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            7'b0100011: begin
                dec.alu_op = 4'b0010; dec.src_b_sel = 2'b01; dec.imm = imm_s;
                dec.illegal = (funct3 > 3'd2);
            end
            7'b0010011: begin
                dec.alu_op = f3_op(funct3, funct7[5]); dec.src_b_sel = 2'b01;
                dec.imm = imm_i; dec.rd_we = 1'b1;
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    dec.illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec.illegal = 1'b1;
            end
            7'b0110011: begin
                dec.rd_we = 1'b1;
                if (funct7 == 7'b0000000)
                    dec.alu_op = f3_op(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                    dec.alu_op = 4'b0011;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101)
                    dec.alu_op = 4'b0111;
                else
                    dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal encodings still travel down the pipe, but carry no operation.
        if (dec.illegal) begin
            dec.alu_op    = 4'b0000;
            dec.src_a_sel = 1'b0;
            dec.src_b_sel = 2'b00;
            dec.imm       = '0;
            dec.rd_we     = 1'b0;
        end
        if (dec.rd == 5'd0)
            dec.rd_we = 1'b0;
    end

    dec_t out_reg, out_next, skid_reg, skid_next;
    logic out_valid_reg, out_valid_next, skid_full_reg, skid_full_next;
    logic accept, drain;

    assign in_ready = ~skid_full_reg;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_reg & out_ready;

    always_comb begin
        out_next       = out_reg;
        skid_next      = skid_reg;
        out_valid_next = out_valid_reg;
        skid_full_next = skid_full_reg;
        if (flush) begin
            out_valid_next = 1'b0;
            skid_full_next = 1'b0;
        end else if (!out_valid_reg || drain) begin
            // Skid holds the older instruction, so it always goes first.
            if (skid_full_reg) begin
                out_next       = skid_reg;
                out_valid_next = 1'b1;
                skid_full_next = 1'b0;
            end else if (accept) begin
                out_next       = dec;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next      = dec;
            skid_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg       <= '0;
            skid_reg      <= '0;
            out_valid_reg <= 1'b0;
            skid_full_reg <= 1'b0;
        end else begin
            out_reg       <= out_next;
            skid_reg      <= skid_next;
            out_valid_reg <= out_valid_next;
            skid_full_reg <= skid_full_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign alu_op    = out_reg.alu_op;
    assign src_a_sel = out_reg.src_a_sel;
    assign src_b_sel = out_reg.src_b_sel;
    assign imm       = out_reg.imm;
    assign rs1       = out_reg.rs1;
    assign rs2       = out_reg.rs2;
    assign rd        = out_reg.rd;
    assign rd_we     = out_reg.rd_we;
    assign illegal   = out_reg.illegal;
    assign out_pc    = out_reg.pc;

endmodule
